// File: rtl/mips_pkg.sv
// Shared MIPS core types: instruction opcode/funct encodings plus the
// multiply/divide unit's operation and sequencer state enums.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'b000000,
    OP_J       = 6'b000010,
    OP_JAL     = 6'b000011,
    OP_BEQ     = 6'b000100,
    OP_BNE     = 6'b000101,
    OP_ADDIU   = 6'b001001,
    OP_LW      = 6'b100011,
    OP_SW      = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'b000000,
    FN_JR    = 6'b001000,
    FN_MFHI  = 6'b010000,
    FN_MTHI  = 6'b010001,
    FN_MFLO  = 6'b010010,
    FN_MTLO  = 6'b010011,
    FN_MULT  = 6'b011000,
    FN_MULTU = 6'b011001,
    FN_DIV   = 6'b011010,
    FN_DIVU  = 6'b011011,
    FN_ADDU  = 6'b100001,
    FN_SUBU  = 6'b100011
  } funct_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_sign_cond.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
module md_sign_cond #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one result bit per
// cycle on a shared 2*WIDTH shift accumulator, sign fixup in a final cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t          state, state_nxt;
  md_op_t             op_in, op_r;
  logic               signed_in, div_in, div_r, neg_a, neg_b, last_iter;
  logic               neg_res_r, neg_rem_r, dz_r;
  logic [WIDTH-1:0]   a_r, opd_r, a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] acc_r, mul_nxt, div_nxt, prod_fix;
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [CNT_W-1:0]   cnt_r;

  assign op_in     = md_op_t'(op);
  assign signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign div_r     = (op_r == MD_DIV) || (op_r == MD_DIVU);
  assign neg_a     = signed_in & a[WIDTH-1];
  assign neg_b     = signed_in & b[WIDTH-1];
  assign last_iter = (cnt_r == CNT_W'(WIDTH - 1));

  md_sign_cond #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .din(a), .dout(a_abs));
  md_sign_cond #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .din(b), .dout(b_abs));

  // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
  assign add_sum = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opd_r};
  assign mul_nxt = acc_r[0] ? {add_sum, acc_r[WIDTH-1:1]}
                            : {1'b0, acc_r[2*WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shift left, trial subtract.
  assign rem_sh  = acc_r[2*WIDTH-1:WIDTH-1];
  assign diff    = rem_sh - {1'b0, opd_r};
  assign div_nxt = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                    acc_r[WIDTH-2:0], ~diff[WIDTH]};

  md_sign_cond #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg(neg_res_r), .din(acc_r), .dout(prod_fix));
  md_sign_cond #(.WIDTH(WIDTH)) u_fix_quo (
    .neg(neg_res_r), .din(acc_r[WIDTH-1:0]), .dout(quo_fix));
  md_sign_cond #(.WIDTH(WIDTH)) u_fix_rem (
    .neg(neg_rem_r), .din(acc_r[2*WIDTH-1:WIDTH]), .dout(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = div_in ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        stall = 1'b1;
        if (last_iter) state_nxt = ST_FIXUP;
      end
      ST_FIXUP: begin
        stall     = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= MD_MULT;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      a_r       <= '0;
      opd_r     <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r      <= op_in;
            neg_res_r <= neg_a ^ neg_b;
            neg_rem_r <= neg_a;
            dz_r      <= (b == '0);
            a_r       <= a;
            // Divide iterates on |a| against |b|; multiply on |b| adding |a|.
            opd_r     <= div_in ? b_abs : a_abs;
            acc_r     <= {{WIDTH{1'b0}}, (div_in ? a_abs : b_abs)};
            cnt_r     <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_MUL: begin
          acc_r <= mul_nxt;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_DIV: begin
          acc_r <= div_nxt;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_FIXUP: begin
          if (!div_r) begin
            {hi, lo} <= prod_fix;
          end else if (dz_r) begin
            hi <= a_r;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a cycle-level
// reference model built from plain 64-bit arithmetic and a latency counter.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] wdata = '0;
  logic         stall, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;
  int stall_cyc = 0;

  int           m_phase;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Returns {hi, lo} for a completed operation.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // m_phase counts cycles since issue (0 = idle); result lands at phase W+2.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
    end else if (m_phase == 0) begin
      if (start) begin
        {p_hi, p_lo} <= ref_md(op, a, b);
        m_phase      <= 1;
      end else begin
        if (mthi) m_hi <= wdata;
        if (mtlo) m_lo <= wdata;
      end
    end else if (m_phase == W + 1) begin
      m_hi    <= p_hi;
      m_lo    <= p_lo;
      m_phase <= W + 2;
    end else if (m_phase == W + 2) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_stall, exp_done;
    exp_stall = ((m_phase == 0) && start) || ((m_phase >= 1) && (m_phase <= W + 1));
    exp_done  = (m_phase == W + 2);
    check("cyc_stall", {31'b0, stall}, {31'b0, exp_stall});
    check("cyc_done",  {31'b0, done},  {31'b0, exp_done});
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    if (stall === 1'b1) stall_cyc++;
  end

  task automatic pulse_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    stall_cyc = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int lat;
    pulse_start(o, x, y);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'd34);
    check({name, "_stallcyc"}, 32'(stall_cyc), 32'd34);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu");
    run_op(2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "div_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

    // MTLO while multiplying must not disturb LO
    @(posedge clk); #1;
    mtlo = 1'b1; wdata = 32'h0000_A5A5;
    @(posedge clk); #1;
    mtlo = 1'b0;
    pulse_start(2'b01, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    mtlo = 1'b1; mthi = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    mtlo = 1'b0; mthi = 1'b0;
    check("mtlo_busy_lo", lo, 32'h0000_A5A5);
    wait_done(lat);
    check("mtlo_busy_reached_done", {31'b0, done}, 32'h1);
    check("mtlo_busy_res_hi", hi, 32'h0);
    check("mtlo_busy_res_lo", lo, 32'd15);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      mthi  = ($urandom_range(0, 3) == 0);
      mtlo  = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of a multiply aborts it and clears HI/LO
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_5555;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    pulse_start(2'b01, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    check("mid_stall_before", {31'b0, stall}, 32'h1);
    check("mid_hi_before", hi, 32'h0000_5555);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", {31'b0, stall}, 32'h0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_done", {31'b0, done}, 32'h0);
    check("post_rst_lo", lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
